fetch_prefetch_queue: RTL and testbench

//  Instruction fetch stage between the instruction ROM and the Core, replacing the direct PC->ROM wiring.

---
 rtl/fetch_prefetch_queue.sv | 224 ++++++++++++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage: issues one outstanding ROM read at a time and buffers returned
// words with their PCs in a small FIFO delivered to the core over valid/ready.
`timescale 1ns/1ps
module fetch_prefetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  output logic                       rom_req,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic                       rom_ack,
  input  logic [DATA_W-1:0]          rom_data,
  output logic [DATA_W-1:0]          instr,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int unsigned       CW       = $clog2(DEPTH + 1);
  localparam int unsigned       PW       = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
  localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0]     PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]     PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   fetch_pc_r, fetch_pc_s;
  logic                rom_req_r, rom_req_s;
  logic [ADDR_W-1:0]   rom_addr_r, rom_addr_s;
  logic [CW-1:0]       count_r, count_s;
  logic [PW-1:0]       rd_ptr_r, rd_ptr_s;
  logic [PW-1:0]       wr_ptr_r, wr_ptr_s;
  logic [DATA_W-1:0]   mem_data_r [DEPTH];
  logic [ADDR_W-1:0]   mem_pc_r   [DEPTH];
  logic [DATA_W-1:0]   instr_r, instr_s;
  logic [ADDR_W-1:0]   instr_pc_r, instr_pc_s;
  logic                instr_valid_r, instr_valid_s;
  logic                push_s;
  logic                pop_s;
  logic                room_s;

  // A redirect cancels any pop in the same cycle.
  assign pop_s  = instr_valid_r & instr_ready & ~redirect;
  // Space left for one more outstanding request after this cycle's push and pop.
  assign room_s = ((count_r + CNT_ONE) - {{(CW-1){1'b0}}, pop_s}) < DEPTH_C;

  // Fetch FSM: next state, request/address and fetch PC.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    rom_req_s  = rom_req_r;
    rom_addr_s = rom_addr_r;
    push_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_s = redirect_pc;
          rom_req_s  = 1'b1;
          rom_addr_s = redirect_pc;
          state_s    = ST_REQ;
        end else if (count_r < DEPTH_C) begin
          rom_req_s  = 1'b1;
          rom_addr_s = fetch_pc_r;
          state_s    = ST_REQ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          fetch_pc_s = redirect_pc;
          if (rom_ack) begin
            rom_addr_s = redirect_pc;
            state_s    = ST_REQ;
          end else begin
            state_s = ST_DROP;
          end
        end else if (rom_ack) begin
          push_s     = 1'b1;
          fetch_pc_s = fetch_pc_r + STEP;
          if (room_s) begin
            rom_addr_s = fetch_pc_r + STEP;
          end else begin
            rom_req_s = 1'b0;
            state_s   = ST_IDLE;
          end
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_DROP: begin
        // The cancelled word is discarded; the next request targets the latest redirect.
        if (rom_ack) begin
          fetch_pc_s = redirect ? redirect_pc : fetch_pc_r;
          rom_addr_s = redirect ? redirect_pc : fetch_pc_r;
          state_s    = ST_REQ;
        end else if (redirect) begin
          fetch_pc_s = redirect_pc;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        rom_req_s = 1'b0;
      end
    endcase
  end

  // Queue pointers, occupancy and the head value presented after this edge.
  always_comb begin
    count_s       = count_r;
    rd_ptr_s      = rd_ptr_r;
    wr_ptr_s      = wr_ptr_r;
    instr_s       = instr_r;
    instr_pc_s    = instr_pc_r;
    instr_valid_s = 1'b0;
    if (redirect) begin
      count_s  = CNT_ZERO;
      rd_ptr_s = PTR_ZERO;
      wr_ptr_s = PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + CNT_ONE;
        2'b01:   count_s = count_r - CNT_ONE;
        default: count_s = count_r;
      endcase
      instr_valid_s = (count_s != CNT_ZERO);
      // A push into an otherwise empty queue becomes the head directly.
      if (push_s && (count_s == CNT_ONE)) begin
        instr_s    = rom_data;
        instr_pc_s = rom_addr_r;
      end else if (count_s != CNT_ZERO) begin
        instr_s    = mem_data_r[rd_ptr_s];
        instr_pc_s = mem_pc_r[rd_ptr_s];
      end else begin
        instr_s    = instr_r;
        instr_pc_s = instr_pc_r;
      end
    end
  end

  // Fetch control registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      rom_req_r  <= 1'b0;
      rom_addr_r <= RESET_PC;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      rom_req_r  <= rom_req_s;
      rom_addr_r <= rom_addr_s;
    end
  end

  // Queue storage and bookkeeping.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count_r  <= CNT_ZERO;
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= {DATA_W{1'b0}};
        mem_pc_r[i]   <= {ADDR_W{1'b0}};
      end
    end else begin
      count_r  <= count_s;
      rd_ptr_r <= rd_ptr_s;
      wr_ptr_r <= wr_ptr_s;
      if (push_s) begin
        mem_data_r[wr_ptr_r] <= rom_data;
        mem_pc_r[wr_ptr_r]   <= rom_addr_r;
      end
    end
  end

  // Registered core-side head outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      instr_r       <= {DATA_W{1'b0}};
      instr_pc_r    <= {ADDR_W{1'b0}};
      instr_valid_r <= 1'b0;
    end else begin
      instr_r       <= instr_s;
      instr_pc_r    <= instr_pc_s;
      instr_valid_r <= instr_valid_s;
    end
  end

  assign rom_req     = rom_req_r;
  assign rom_addr    = rom_addr_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;
  assign q_count     = count_r;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: a scoreboard of {pc, word} pushed on each accepted
// ROM ack and popped on each core handshake, plus directed checks of control outputs.
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  q_count;

  logic        rst2_n;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic        w_valid;
  logic [2:0]  w_count;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop = 0;
  logic [63:0] sb[$];
  logic        dropping = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'h0;
  logic [31:0] pcs2[$];
  logic [31:0] dat2[$];
  int          pop_base;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  fetch_prefetch_queue dut (
    .Clk(Clk), .Rst_n(Rst_n), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_data(rom_data), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc), .q_count(q_count)
  );

  fetch_prefetch_queue #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk(Clk), .Rst_n(rst2_n), .rom_req(w_req), .rom_addr(w_addr), .rom_ack(1'b1),
    .rom_data(w_data), .instr(w_instr), .instr_pc(w_pc), .instr_valid(w_valid),
    .instr_ready(1'b1), .redirect(1'b0), .redirect_pc(32'h0), .q_count(w_count)
  );

  assign w_data = rom_fn(w_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: predict the edge from current inputs/outputs, then advance to the next negedge.
  task automatic cyc();
    logic [63:0] e;
    rom_data = ovr_en ? ovr_val : rom_fn(rom_addr);
    if (redirect) begin
      if (rom_req && !rom_ack) dropping = 1'b1;
      else if (rom_req && rom_ack) dropping = 1'b0;
      sb.delete();
    end else begin
      if (instr_valid && instr_ready) begin
        n_vec++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL sb_underflow: observed pop of pc %0h expected no valid word", instr_pc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          n_pop++;
          chk("pop_pc", {32'h0, instr_pc}, {32'h0, e[63:32]});
          chk("pop_data", {32'h0, instr}, {32'h0, e[31:0]});
        end
      end
      if (rom_req && rom_ack) begin
        if (dropping) dropping = 1'b0;
        else sb.push_back({rom_addr, rom_data});
      end
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    sb.delete();
    dropping = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    Rst_n = 1'b0; rst2_n = 1'b0; rom_ack = 1'b0; rom_data = 32'h0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge Clk);
    chk("rst_req", {63'h0, rom_req}, 64'h0);
    chk("rst_addr", {32'h0, rom_addr}, 64'h0);
    chk("rst_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_instr", {32'h0, instr}, 64'h0);
    chk("rst_pc", {32'h0, instr_pc}, 64'h0);
    chk("rst_count", {61'h0, q_count}, 64'h0);

    // Reset asserted mid-request, then first fetch after release.
    Rst_n = 1'b1;
    cyc();
    chk("t1_first_req", {63'h0, rom_req}, 64'h1);
    rom_ack = 1'b1;
    cyc(); cyc();
    rom_ack = 1'b0;
    chk("t1_addr8", {32'h0, rom_addr}, 64'h8);
    chk("t1_valid_pre", {63'h0, instr_valid}, 64'h1);
    Rst_n = 1'b0; sb.delete(); dropping = 1'b0;
    #1;
    chk("t1_async_req", {63'h0, rom_req}, 64'h0);
    chk("t1_async_addr", {32'h0, rom_addr}, 64'h0);
    chk("t1_async_valid", {63'h0, instr_valid}, 64'h0);
    chk("t1_async_instr", {32'h0, instr}, 64'h0);
    chk("t1_async_count", {61'h0, q_count}, 64'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    cyc();
    chk("t1_restart_req", {63'h0, rom_req}, 64'h1);
    chk("t1_restart_addr", {32'h0, rom_addr}, 64'h0);

    // Streaming at one instruction per cycle.
    rom_ack = 1'b1; instr_ready = 1'b1;
    pop_base = n_pop;
    repeat (12) cyc();
    chk("t2_pops", 64'(n_pop - pop_base), 64'd11);
    chk("t2_count", {61'h0, q_count}, 64'h1);

    // Fill with core stalled, then drain and resume.
    rom_ack = 1'b0; instr_ready = 1'b0;
    do_reset();
    cyc();
    rom_ack = 1'b1;
    repeat (4) cyc();
    chk("t3_full_count", {61'h0, q_count}, 64'h4);
    chk("t3_full_req", {63'h0, rom_req}, 64'h0);
    cyc();
    chk("t3_hold_count", {61'h0, q_count}, 64'h4);
    chk("t3_hold_req", {63'h0, rom_req}, 64'h0);
    rom_ack = 1'b0; instr_ready = 1'b1;
    repeat (4) cyc();
    chk("t3_drained", {61'h0, q_count}, 64'h0);
    chk("t3_sb_empty", 64'(sb.size()), 64'h0);
    chk("t3_resume_req", {63'h0, rom_req}, 64'h1);
    chk("t3_resume_addr", {32'h0, rom_addr}, 64'h10);

    // Redirect with a request outstanding; late ack must be dropped.
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    chk("t4_hold_addr", {32'h0, rom_addr}, 64'h10);
    chk("t4_hold_req", {63'h0, rom_req}, 64'h1);
    cyc(); cyc();
    ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF; rom_ack = 1'b1;
    cyc();
    ovr_en = 1'b0; rom_ack = 1'b0;
    chk("t4_new_addr", {32'h0, rom_addr}, 64'h100);
    chk("t4_no_valid", {63'h0, instr_valid}, 64'h0);
    chk("t4_count", {61'h0, q_count}, 64'h0);
    rom_ack = 1'b1;
    repeat (6) cyc();

    // Redirect, ack and pop in the same cycle.
    chk("t5_pre_valid", {63'h0, instr_valid}, 64'h1);
    redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    chk("t5_count", {61'h0, q_count}, 64'h0);
    chk("t5_valid", {63'h0, instr_valid}, 64'h0);
    chk("t5_addr", {32'h0, rom_addr}, 64'h200);
    chk("t5_req", {63'h0, rom_req}, 64'h1);
    repeat (5) cyc();

    // Redirect while idle with a full queue.
    instr_ready = 1'b0;
    repeat (5) cyc();
    chk("t5i_full", {61'h0, q_count}, 64'h4);
    chk("t5i_idle_req", {63'h0, rom_req}, 64'h0);
    redirect = 1'b1; redirect_pc = 32'h300; rom_ack = 1'b0;
    cyc();
    redirect = 1'b0;
    chk("t5i_count", {61'h0, q_count}, 64'h0);
    chk("t5i_req", {63'h0, rom_req}, 64'h1);
    chk("t5i_addr", {32'h0, rom_addr}, 64'h300);
    rom_ack = 1'b1; instr_ready = 1'b1;
    repeat (4) cyc();
    chk("t5i_sb_depth", 64'(sb.size()), {61'h0, q_count});

    // PC wrap from RESET_PC = 0xFFFFFFFC.
    chk("t6_rst_addr", {32'h0, w_addr}, 64'hFFFF_FFFC);
    chk("t6_rst_req", {63'h0, w_req}, 64'h0);
    chk("t6_rst_count", {61'h0, w_count}, 64'h0);
    rst2_n = 1'b1;
    repeat (6) begin
      @(posedge Clk);
      @(negedge Clk);
      if (w_valid) begin
        pcs2.push_back(w_pc);
        dat2.push_back(w_instr);
      end
    end
    n_vec++;
    assert (pcs2.size() >= 3) else begin
      n_err++;
      $error("FAIL t6_words: observed %0d words expected at least 3", pcs2.size());
    end
    if (pcs2.size() >= 3) begin
      chk("t6_pc0", {32'h0, pcs2[0]}, 64'hFFFF_FFFC);
      chk("t6_data0", {32'h0, dat2[0]}, {32'h0, rom_fn(32'hFFFF_FFFC)});
      chk("t6_pc1", {32'h0, pcs2[1]}, 64'h0);
      chk("t6_data1", {32'h0, dat2[1]}, {32'h0, rom_fn(32'h0)});
      chk("t6_pc2", {32'h0, pcs2[2]}, 64'h4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
